rr_encoder_mux: RTL and testbench



---
 rtl/rr_encoder_mux.sv | 145 ++++++++++++++
 tb/tb_rr_encoder_mux.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rr_encoder_mux.sv
// Round-robin collector: arbitrates four requesting channels, registers the
// winner's index and data, and presents them on a valid/ready output port.
module rr_encoder_mux #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [1:0]    out_sel,
    output logic [DW-1:0] out_data,
    output logic [3:0]    ack,
    output logic          busy,
    output logic [CW-1:0] xfer_cnt
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    sel_q,   sel_d;
    logic [DW-1:0] data_q,  data_d;
    logic [3:0]    ack_q,   ack_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [1:0]    ptr_q,   ptr_d;

    logic          accept;
    logic [3:0]    mask;
    logic [3:0]    elig;
    logic [1:0]    win;
    logic [1:0]    idx;
    logic          found;
    logic          load;
    logic [DW-1:0] win_data;

    // The word being accepted is masked so its channel cannot be re-granted
    // on the same edge it is acknowledged.
    assign accept = (state_q == HOLD) && out_ready;
    assign mask   = accept ? (4'b0001 << sel_q) : '0;
    assign elig   = req & ~mask;

    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        unique case (win)
            2'd0:    win_data = din0;
            2'd1:    win_data = din1;
            2'd2:    win_data = din2;
            default: win_data = din3;
        endcase
    end

    // A new word is captured from IDLE, or on the accept edge in HOLD.
    assign load = found && ((state_q == IDLE) || accept);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept && !found) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d  = sel_q;
        data_d = data_q;
        ack_d  = '0;
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        if (load) begin
            sel_d  = win;
            data_d = win_data;
        end
        if (accept) begin
            ack_d = 4'b0001 << sel_q;
            cnt_d = cnt_q + CW'(1);
            ptr_d = sel_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            data_q <= '0;
            ack_q  <= '0;
            cnt_q  <= '0;
            ptr_q  <= '0;
        end else begin
            sel_q  <= sel_d;
            data_q <= data_d;
            ack_q  <= ack_d;
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
        end
    end

    // Output logic: decoded only from registered state
    always_comb begin
        out_valid = (state_q == HOLD);
        busy      = (state_q == HOLD);
        out_sel   = sel_q;
        out_data  = data_q;
        ack       = ack_q;
        xfer_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_rr_encoder_mux.sv
// Directed bench for rr_encoder_mux: reset, single grant, pointer wrap,
// backpressure, asynchronous reset mid-transfer, full contention, counter wrap.
module tb_rr_encoder_mux;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;

    logic          clk;
    logic          clk_en;
    logic          rst_n;
    logic [3:0]    req;
    logic [DW-1:0] din0, din1, din2, din3;
    logic          out_ready;
    logic          out_valid;
    logic [1:0]    out_sel;
    logic [DW-1:0] out_data;
    logic [3:0]    ack;
    logic          busy;
    logic [CW-1:0] xfer_cnt;

    int unsigned vectors;
    int unsigned miscompares;

    rr_encoder_mux #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din0      (din0),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .out_data  (out_data),
        .ack       (ack),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [1:0] s,
                           input logic [7:0] d, input logic [3:0] a, input logic [7:0] c);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_busy"},  32'(busy),      32'(v));
        chk({tag, "_sel"},   32'(out_sel),   32'(s));
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_ack"},   32'(ack),       32'(a));
        chk({tag, "_cnt"},   32'(xfer_cnt),  32'(c));
    endtask

    logic [1:0] c_sel  [6];
    logic [7:0] c_data [6];
    logic [3:0] c_ack  [6];
    logic [7:0] c_cnt  [6];

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk_en      = 1'b0;
        rst_n       = 1'b1;
        req         = 4'b0000;
        din0        = 8'h00;
        din1        = 8'h00;
        din2        = 8'h00;
        din3        = 8'h00;
        out_ready   = 1'b0;

        // Reset with no clock running
        #2 rst_n = 1'b0;
        #2 chk_all("reset", 1'b0, 2'd0, 8'h00, 4'b0000, 8'd0);
        #3 rst_n = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Single request on channel 2
        req = 4'b0100; din2 = 8'hA5; out_ready = 1'b1;
        @(negedge clk);
        chk_all("single_grant", 1'b1, 2'd2, 8'hA5, 4'b0000, 8'd0);
        @(negedge clk);
        chk_all("single_ack", 1'b0, 2'd2, 8'hA5, 4'b0100, 8'd1);
        req = 4'b0000;
        @(negedge clk);
        chk("single_ack_off", 32'(ack), 32'd0);
        chk("single_idle", 32'(out_valid), 32'd0);

        // Pointer at 3: channel 3 wins before channel 0
        req = 4'b1001; din0 = 8'h50; din3 = 8'h53;
        @(negedge clk);
        chk_all("wrap_g3", 1'b1, 2'd3, 8'h53, 4'b0000, 8'd1);
        @(negedge clk);
        chk_all("wrap_g0", 1'b1, 2'd0, 8'h50, 4'b1000, 8'd2);
        req = 4'b0001;
        @(negedge clk);
        chk_all("wrap_end", 1'b0, 2'd0, 8'h50, 4'b0001, 8'd3);
        req = 4'b0000;
        @(negedge clk);
        chk("wrap_ack_off", 32'(ack), 32'd0);

        // Backpressure on a channel 1 word
        req = 4'b0010; din1 = 8'h3C; out_ready = 1'b0;
        @(negedge clk);
        chk_all("bp_grant", 1'b1, 2'd1, 8'h3C, 4'b0000, 8'd3);
        din1 = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_all($sformatf("bp_hold%0d", i), 1'b1, 2'd1, 8'h3C, 4'b0000, 8'd3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk_all("bp_ack", 1'b0, 2'd1, 8'h3C, 4'b0010, 8'd4);
        req = 4'b0000;
        @(negedge clk);
        chk("bp_ack_off", 32'(ack), 32'd0);

        // Asynchronous reset while channel 3 is held
        req = 4'b1000; din3 = 8'h77; out_ready = 1'b0;
        @(negedge clk);
        chk_all("rst_pre", 1'b1, 2'd3, 8'h77, 4'b0000, 8'd4);
        #2 rst_n = 1'b0;
        #1 chk_all("rst_async", 1'b0, 2'd0, 8'h00, 4'b0000, 8'd0);
        @(negedge clk);
        chk_all("rst_held", 1'b0, 2'd0, 8'h00, 4'b0000, 8'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk_all("rst_regrant", 1'b1, 2'd3, 8'h77, 4'b0000, 8'd0);
        @(negedge clk);
        chk_all("rst_ack", 1'b0, 2'd3, 8'h77, 4'b1000, 8'd1);
        req = 4'b0000;
        @(negedge clk);
        chk("rst_ack_off", 32'(ack), 32'd0);

        // Full contention, pointer starts at 0
        c_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        c_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
        c_ack  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        c_cnt  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        req = 4'b1111; din0 = 8'h10; din1 = 8'h11; din2 = 8'h12; din3 = 8'h13;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_all($sformatf("rr%0d", i), 1'b1, c_sel[i], c_data[i], c_ack[i], c_cnt[i]);
        end
        req = 4'b0000;
        @(negedge clk);
        chk_all("rr_end", 1'b0, 2'd1, 8'h11, 4'b0010, 8'd7);
        @(negedge clk);
        chk("rr_ack_off", 32'(ack), 32'd0);

        // Transfer counter wraps at 256
        req = 4'b1111;
        @(negedge clk);
        chk("cw_start", 32'(xfer_cnt), 32'd7);
        repeat (248) @(negedge clk);
        chk("cw_255", 32'(xfer_cnt), 32'd255);
        @(negedge clk);
        chk("cw_wrap", 32'(xfer_cnt), 32'd0);
        chk("cw_valid", 32'(out_valid), 32'd1);
        req = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
